// File: rtl/video_text_dump.sv
// Text-mode screen dumper: walks the character RAM row by row and
// streams each cell as a byte, with CR/LF after every row.
module video_text_dump #(
    parameter int          COLS       = 64,
    parameter int          ROWS       = 48,
    parameter int          ADDR_WIDTH = 12,
    parameter int          RD_LATENCY = 1,
    parameter logic [7:0]  SUB_CHAR   = 8'h2E
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [7:0]            rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = ADDR_WIDTH - CW;
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_CR,
        S_LF,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [RW-1:0]         r_row;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         w_col;
    logic [LW-1:0]         r_lat;
    logic [LW-1:0]         w_lat;
    logic [7:0]            r_tx_data;
    logic [7:0]            w_tx_data;
    logic                  r_tx_valid;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_printable;

    assign w_accept    = r_tx_valid & tx_ready;
    assign w_printable = (rd_data >= 8'h20) && (rd_data < 8'h7F);

    // State, counters and all outputs; outputs follow the next state
    // so every port is a flop and the cell timing stays one per state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_lat      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_row      <= w_row;
            r_col      <= w_col;
            r_lat      <= w_lat;
            r_tx_data  <= w_tx_data;
            r_rd_en    <= (w_next == S_READ);
            r_tx_valid <= (w_next == S_SEND) || (w_next == S_CR) ||
                          (w_next == S_LF);
            r_busy     <= (w_next != S_IDLE) && (w_next != S_FIN);
            r_done     <= (w_next == S_FIN);
            if (w_next == S_READ) begin
                r_rd_addr <= {w_row, w_col};
            end
        end
    end

    // Next-state, counter and byte selection; a lost mem_ready aborts.
    always_comb begin
        w_next    = r_state;
        w_row     = r_row;
        w_col     = r_col;
        w_lat     = r_lat;
        w_tx_data = r_tx_data;
        unique case (r_state)
            S_IDLE: begin
                if (start && mem_ready) begin
                    w_next = S_READ;
                    w_row  = '0;
                    w_col  = '0;
                end
            end
            S_READ: begin
                w_next = S_WAIT;
                w_lat  = '0;
            end
            S_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_next    = S_SEND;
                    w_tx_data = w_printable ? rd_data : SUB_CHAR;
                end else begin
                    w_lat = r_lat + 1'b1;
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    if (r_col != COL_LAST) begin
                        w_col  = r_col + 1'b1;
                        w_next = S_READ;
                    end else begin
                        w_col     = '0;
                        w_next    = S_CR;
                        w_tx_data = 8'h0D;
                    end
                end
            end
            S_CR: begin
                if (w_accept) begin
                    w_next    = S_LF;
                    w_tx_data = 8'h0A;
                end
            end
            S_LF: begin
                if (w_accept) begin
                    if (r_row != ROW_LAST) begin
                        w_row  = r_row + 1'b1;
                        w_next = S_READ;
                    end else begin
                        w_next = S_FIN;
                    end
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (!mem_ready && (r_state != S_IDLE) && (r_state != S_FIN)) begin
            w_next = S_IDLE;
        end
    end

    assign rd_addr  = r_rd_addr;
    assign rd_en    = r_rd_en;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_video_text_dump.sv
// Directed bench for video_text_dump: RAM model, byte sink with
// optional stalls, and a byte-level model of the expected dump.
module tb_video_text_dump;

    localparam int NBYTES = 48 * 66;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mem_ready;
    logic [11:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:4095];
    logic [7:0]  got_q [$];
    logic [11:0] rd_q [$];

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int stab_err = 0;
    int stall_cyc = 0;
    int stall_left = 0;
    bit stall_en = 1'b0;
    bit prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int q_base = 0;
    int d_base = 0;
    int r_base = 0;

    video_text_dump dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem_ready (mem_ready),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model, one cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Sink: picks tx_ready, records accepted bytes, reads and done pulses
    always @(negedge clk) begin
        if (stall_en && tx_valid && !prev_hold && stall_left == 0 &&
            $urandom_range(0, 3) == 0)
            stall_left = $urandom_range(1, 10);
        if (stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
            stall_cyc++;
        end else begin
            tx_ready = 1'b1;
        end
        if (prev_hold && (!tx_valid || tx_data !== prev_data))
            stab_err++;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (done) done_cnt++;
        if (rd_en) rd_q.push_back(rd_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        int r;
        int c;
        logic [7:0] v;
        r = i / 66;
        c = i % 66;
        if (c == 64) return 8'h0D;
        if (c == 65) return 8'h0A;
        v = mem[12'(r * 64 + c)];
        if (v < 8'h20 || v >= 8'h7F) return 8'h2E;
        return v;
    endfunction

    task automatic mark();
        q_base = got_q.size();
        d_base = done_cnt;
        r_base = rd_q.size();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == d_base && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d_base)
            chk({tag, "_timeout"}, 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_bytes(input string tag, input int n,
                              input int budget);
        int k = 0;
        while (got_q.size() - q_base < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (got_q.size() - q_base < n)
            chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_dump(input string tag);
        int nbad = 0;
        int len;
        logic [11:0] amax = 12'h000;
        len = got_q.size() - q_base;
        for (int i = 0; i < len && i < NBYTES; i++)
            if (got_q[q_base + i] !== exp_byte(i)) nbad++;
        for (int i = r_base; i < rd_q.size(); i++)
            if (rd_q[i] > amax) amax = rd_q[i];
        chk({tag, "_len"}, len, NBYTES);
        chk({tag, "_bad"}, nbad, 0);
        chk({tag, "_done"}, done_cnt - d_base, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_addr0"}, rd_q[r_base], 12'h000);
        chk({tag, "_amax"}, amax, 12'hBFF);
        chk({tag, "_nrd"}, rd_q.size() - r_base, 3072);
    endtask

    task automatic do_dump(input string tag, input int budget);
        mark();
        pulse_start();
        wait_done(tag, budget);
        check_dump(tag);
    endtask

    initial begin
        int sbase;
        int ebase;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h20;
        mem[12'h000] = 8'h41;
        mem[12'h041] = 8'h07;
        mem[12'h0C5] = 8'h7F;
        mem[12'h100] = 8'h7E;
        reset_n   = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_rden", rd_en, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", tx_data, 0);
        reset_n = 1'b1;

        // start without mem_ready is dropped
        mark();
        pulse_start();
        repeat (6) @(negedge clk);
        chk("nordy_rden", rd_q.size() - r_base, 0);
        chk("nordy_busy", busy, 0);
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);

        // first dump: latency, content, start pulses while busy
        mark();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_rden", rd_en, 1);
        chk("t1_addr", rd_addr, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t2_valid", tx_valid, 0);
        @(negedge clk);
        chk("t3_valid", tx_valid, 1);
        chk("t3_data", tx_data, 8'h41);
        wait_bytes("busy200", 200, 2000);
        pulse_start();
        wait_bytes("busy1000", 1000, 6000);
        pulse_start();
        wait_done("dumpA", 16000);
        check_dump("dumpA");
        chk("b0", got_q[q_base + 0], 8'h41);
        chk("b64", got_q[q_base + 64], 8'h0D);
        chk("b65", got_q[q_base + 65], 8'h0A);
        chk("b67", got_q[q_base + 67], 8'h2E);
        chk("b203_7f", got_q[q_base + 203], 8'h2E);
        chk("b264_7e", got_q[q_base + 264], 8'h7E);
        chk("b_last", got_q[q_base + NBYTES - 1], 8'h0A);
        repeat (10) @(negedge clk);
        chk("dumpA_once", done_cnt - d_base, 1);

        // random sink stalls
        sbase = stall_cyc;
        ebase = stab_err;
        stall_en = 1'b1;
        do_dump("stall", 30000);
        stall_en = 1'b0;
        chk("stall_seen", stall_cyc > sbase, 1);
        chk("stall_stable", stab_err - ebase, 0);

        // reset in row 5, then a fresh full dump
        mark();
        pulse_start();
        wait_bytes("row5", 5 * 66 + 10, 4000);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mr_busy", busy, 0);
        chk("mr_valid", tx_valid, 0);
        chk("mr_rden", rd_en, 0);
        chk("mr_done", done, 0);
        chk("mr_addr", rd_addr, 0);
        chk("mr_data", tx_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        do_dump("afterrst", 16000);

        // mem_ready lost after 100 bytes
        mark();
        pulse_start();
        wait_bytes("drop100", 100, 1000);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("drop_valid", tx_valid, 0);
        chk("drop_busy", busy, 0);
        repeat (6) @(negedge clk);
        chk("drop_nodone", done_cnt - d_base, 0);
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_dump("afterdrop", 16000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
